seg7_mux_display: RTL and testbench
===================================

# seg7_mux_display

Parametrised, time-multiplexed seven-segment display controller for N-digit common-cathode displays. It displays a register value from the CPU (typically R0) in either hex or unsigned decimal. Decimal uses a sequential double-dabble converter, and optional leading-zero blanking and overflow indication are supported. It sits between the CPU's register output and the board's digit/segment pins, replacing the fixed 4-digit hex-only driver.

## Interface
- DATA_W, 16, width of value input
- DIGITS, 4, number of digits driven (≥1)
- REFRESH_DIV, 50000, clk cycles each digit stays enabled (≥1)

- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- din  in  DATA_W  value to display (unsigned)
- load  in  1  single-cycle strobe: capture din and start update
- dec_mode  in  1  sampled with load: 0 = hex, 1 = decimal
- blank_en  in  1  live: 1 = blank leading zero digits
- grounds  out  DIGITS  one-hot digit enable, 1 = digit on; bit 0 = rightmost (least significant)
- display  out  7  segments {g,f,e,d,c,b,a}, 1 = lit
- busy  out  1  decimal conversion in progress
- ovf  out  1  last captured value did not fit in DIGITS digits

## Operation
- Digit buffer: DIGITS × 4-bit codes plus per-digit dash flag; the display always scans this buffer.
- Hex load: nibble i of din → digit i. If any din bit at position ≥ 4·DIGITS is set, ovf=1 and all digits show dash (0x40); otherwise ovf=0.
- Decimal load: capture din. Run double-dabble over DIGITS BCD digits, one bit per cycle for DATA_W cycles; add-3 to every digit ≥5, then shift.
  - Any 1 shifted out of the top BCD digit sets a sticky overflow.
  - At the end, write the buffer (dashes if overflow), update ovf, and clear busy.
- Old buffer contents remain displayed during conversion.
- Load while busy: abort the current conversion and restart with the new din/dec_mode. The latest load always wins.
- Load while idle in hex mode: the buffer is updated directly; busy stays 0.
- Segment map: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71, dash→40.
- Scan:
  - A refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index advances; index DIGITS-1 wraps to 0.
  - grounds = one-hot(index); display = segments of buffer[index].
- Blanking: digit i (i>0) shows display=0 when blank_en=1, no dash is active, and digits i..DIGITS-1 are all 0. Digit 0 is never blanked. grounds still asserts for blanked digits.
- FSM: IDLE → (load & dec_mode) → CONV. CONV stays for DATA_W cycles, then → IDLE with buffer write. load in CONV → CONV restarted. rst → IDLE from any state.

## Timing
- Reset values:
  - grounds = 1 (digit 0), display = 3F
  - busy = 0, ovf = 0
  - buffer all zero, refresh counter 0, index 0, FSM IDLE
- Reset mid-conversion discards the conversion; the buffer is zeroed.
- Hex: load sampled at edge k → buffer/ovf valid after edge k+1; display reflects it when that digit is scanned.
- Decimal: load at edge k → busy=1 after k+1. The last shift happens at k+DATA_W; buffer, ovf written and busy=0 after edge k+DATA_W+1.
- Outputs are registered: grounds and display change together, one cycle after the refresh wrap/index update.
- A digit's on-time is exactly REFRESH_DIV cycles. A full frame is DIGITS·REFRESH_DIV cycles and is unaffected by loads or conversions.
- blank_en acts within one cycle (registered path); no load is required.

## Test plan
- Reset, REFRESH_DIV=4, DIGITS=4 → grounds 0001, display 3F; grounds advance 0001→0010→0100→1000→0001, each held exactly 4 cycles.
- Hex load din=16'hA5F3, blank_en=0 → per-digit display 4F, 71, 6D, 77 (digit 0..3); busy never asserts; ovf=0.
- Decimal load din=1234 → busy high for exactly 16 cycles; then digits show 4,3,2,1 (66, 4F, 5B, 06); ovf=0.
- Decimal din=12345 (DIGITS=4) → ovf=1, all digits 40. Then hex load 16'h0007 with blank_en=1 → digit 0 = 07, digits 1–3 display 00, ovf=0.
- Decimal load 9999, then load 42 five cycles later → busy stays high until 16 cycles after the second load; final digits 2,4 (blanked upper if blank_en=1); 9999 never appears.
- rst asserted mid-conversion → next cycle busy=0, grounds=0001, display=3F; no buffer write afterwards.

Source files
------------

// File: rtl/seg7_mux_display.sv
// seg7_mux_display
//   Time-multiplexed seven-segment controller for an N-digit common-cathode
//   display. It shows a captured value in hex or unsigned decimal. Decimal
//   values go through a bit-serial double-dabble converter.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   din       value to display (unsigned, DATA_W bits)
//   load      one-cycle strobe: capture din / dec_mode and start an update
//   dec_mode  sampled with load: 0 = hex, 1 = decimal
//   blank_en  live control: 1 = blank leading zero digits
//   grounds   one-hot digit enable (bit 0 = rightmost digit)
//   display   segments {g,f,e,d,c,b,a}, 1 = lit
//   busy      decimal conversion in progress
//   ovf       last captured value did not fit in DIGITS digits
//
// Handshake: load is a fire-and-forget strobe with no ready. A load in any
// state is accepted. A later load always replaces an earlier one, including
// one whose conversion is still running. busy reports only whether a decimal
// conversion is in flight. The internal FSM register is named 'state' and
// can be probed hierarchically.
module seg7_mux_display #(
    parameter int DATA_W      = 16,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    input  logic              dec_mode,
    input  logic              blank_en,
    output logic [DIGITS-1:0] grounds,
    output logic [6:0]        display,
    output logic              busy,
    output logic              ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int PAD_W = DATA_W + BCD_W;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state, state_next;

    // Conversion datapath
    logic [DATA_W-1:0] bin;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  bit_cnt;
    logic              sticky;
    logic              shift_out;
    logic              conv_done;
    logic              conv_shift;

    // Hex path: a hex load is written one cycle after it is captured
    logic              hex_pend;
    logic [DATA_W-1:0] hex_val;
    logic [PAD_W-1:0]  hex_pad;
    logic              hex_over;

    // Digit buffer scanned by the display
    logic [BCD_W-1:0]  code_buf;
    logic [DIGITS-1:0] dash_buf;

    // Scan
    logic [RC_W-1:0]   rc;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              wrap;
    logic [DIGITS-1:0] lead_zero;
    logic [DIGITS-1:0] grounds_next;
    logic [6:0]        display_next;

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign conv_done  = (state == CONV) && !load && (bit_cnt == CNT_W'(DATA_W));
    assign conv_shift = (state == CONV) && !load && (bit_cnt != CNT_W'(DATA_W));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load && dec_mode) state_next = CONV;
            end
            CONV: begin
                // A new load restarts (decimal) or aborts (hex) the conversion
                if (load)           state_next = dec_mode ? CONV : IDLE;
                else if (conv_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------- double dabble
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // A 1 leaving the top BCD digit means the value needs more than DIGITS digits
    assign shift_out = bcd_adj[BCD_W-1];

    // Nibble i of the zero-extended value is digit i. Any bit above the
    // digit field means the value cannot be shown.
    always_comb begin
        hex_pad  = PAD_W'(hex_val);
        hex_over = |(hex_pad >> BCD_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            sticky   <= 1'b0;
            hex_pend <= 1'b0;
            hex_val  <= '0;
            code_buf <= '0;
            dash_buf <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (load) begin
                hex_pend <= !dec_mode;
                if (dec_mode) begin
                    bin     <= din;
                    bcd     <= '0;
                    bit_cnt <= '0;
                    sticky  <= 1'b0;
                end else begin
                    hex_val <= din;
                end
            end else begin
                hex_pend <= 1'b0;
                if (conv_shift) begin
                    bcd     <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
                    bin     <= bin << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    sticky  <= sticky | shift_out;
                end
            end

            // A hex write and a conversion write can never share an edge.
            // A pending hex write means the previous edge left or stayed in IDLE.
            if (hex_pend) begin
                code_buf <= hex_pad[BCD_W-1:0];
                dash_buf <= {DIGITS{hex_over}};
                ovf      <= hex_over;
            end else if (conv_done) begin
                code_buf <= bcd;
                dash_buf <= {DIGITS{sticky}};
                ovf      <= sticky;
            end

            busy <= (state == CONV) && !conv_done && !(load && !dec_mode);
        end
    end

    // --------------------------------------------------------------- scan
    assign wrap = (rc == RC_W'(REFRESH_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (wrap) idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // lead_zero[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        logic above;
        above     = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above        = above && (code_buf[4*i +: 4] == 4'd0);
            lead_zero[i] = above;
        end
    end

    // Outputs are registered from the index the counter is moving to. The
    // enable and the segments therefore switch on the same edge, and each
    // digit stays lit for exactly REFRESH_DIV cycles.
    always_comb begin
        int sel;
        sel          = int'(idx_next);
        grounds_next = DIGITS'(1) << idx_next;
        display_next = seg_of(code_buf[sel*4 +: 4]);
        if (dash_buf[sel])
            display_next = 7'h40;
        else if (blank_en && (sel != 0) && !(|dash_buf) && lead_zero[sel])
            display_next = 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc      <= '0;
            idx     <= '0;
            grounds <= DIGITS'(1);
            display <= 7'h3F;
        end else begin
            rc      <= wrap ? '0 : rc + RC_W'(1);
            idx     <= idx_next;
            grounds <= grounds_next;
            display <= display_next;
        end
    end

endmodule

// File: tb/tb_seg7_mux_display.sv
module tb_seg7_mux_display;

  localparam int DATA_W = 16;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int FRAME  = DIGITS * RDIV;
  localparam int W      = 1 + 7 * DIGITS;   // {ovf, seg[DIGITS-1] .. seg[0]}

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              load;
  logic              dec_mode;
  logic              blank_en;
  logic [DIGITS-1:0] grounds;
  logic [6:0]        display;
  logic              busy;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  seg7_mux_display #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS),
    .REFRESH_DIV(RDIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .load(load),
    .dec_mode(dec_mode),
    .blank_en(blank_en),
    .grounds(grounds),
    .display(display),
    .busy(busy),
    .ovf(ovf)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------- reference model
  function automatic logic [6:0] seg_ref(int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // What a full scan frame should look like after loading v.
  function automatic logic [W-1:0] model(int v, bit dec, bit blank);
    logic [W-1:0] r;
    int base;
    int p;
    bit o;
    base = dec ? 10 : 16;
    o    = (v >= base ** DIGITS);
    r    = '0;
    r[W-1] = o;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (o)                          r[7*i +: 7] = 7'h40;
      else if (i > 0 && blank && v < p) r[7*i +: 7] = 7'h00;
      else                            r[7*i +: 7] = seg_ref((v / p) % base);
      p = p * base;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  // Once an expectation is queued, capture one complete scan frame
  // (every digit seen once) and compare it, together with ovf.
  logic [6:0]        cap[DIGITS];
  logic [DIGITS-1:0] seen;

  initial begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    seen = '0;
    forever begin
      @(negedge clk);
      if (rst || exp_q.size() == 0) begin
        seen = '0;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          if (grounds == (DIGITS'(1) << d)) begin
            cap[d]  = display;
            seen[d] = 1'b1;
          end
        end
        if (&seen) begin
          e   = exp_q.pop_front();
          act = '0;
          act[W-1] = ovf;
          for (int d = 0; d < DIGITS; d++) act[7*d +: 7] = cap[d];
          chk("frame", 32'(act), 32'(e));
          seen = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue(int v, bit dec);
    @(negedge clk);
    din      = DATA_W'(v);
    dec_mode = dec;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Called at the first negedge after the load edge.
  task automatic wait_busy(string name, bit dec);
    int cnt;
    bit any;
    if (dec) begin
      @(negedge clk);
      chk({name, "_busy_rise"}, 32'(busy), 32'd1);
      cnt = 0;
      while (busy && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      chk({name, "_busy_len"}, cnt, DATA_W);
    end else begin
      any = 1'b0;
      repeat (3) begin
        any = any | busy;
        @(negedge clk);
      end
      chk({name, "_hex_nobusy"}, 32'(any), 32'd0);
    end
  endtask

  task automatic expect_frame(int v, bit dec, bit blank);
    int n;
    blank_en = blank;
    repeat (2) @(negedge clk);
    exp_q.push_back(model(v, dec, blank));
    n = 0;
    while (exp_q.size() > 0 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("frame_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_load(string name, int v, bit dec, bit blank);
    blank_en = blank;
    issue(v, dec);
    wait_busy(name, dec);
    expect_frame(v, dec, blank);
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    logic [DIGITS-1:0] g_prev;
    int run;
    int trans;
    int v;
    bit d;
    bit b;

    rst = 1'b1; load = 1'b0; din = '0; dec_mode = 1'b0; blank_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grounds", 32'(grounds), 32'd1);
    chk("rst_display", 32'(display), 32'h3F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Scan order and per-digit on-time, starting from the reset sample.
    g_prev = grounds;
    run    = 1;
    trans  = 0;
    for (int c = 0; c < 60 && trans < 8; c++) begin
      @(negedge clk);
      if (grounds === g_prev) begin
        run++;
      end else begin
        chk("scan_hold", run, RDIV);
        chk("scan_order", 32'(grounds), 32'({g_prev[DIGITS-2:0], g_prev[DIGITS-1]}));
        trans++;
        g_prev = grounds;
        run    = 1;
      end
    end
    chk("scan_transitions", trans, 8);

    // Fresh buffer: all zeros, not blanked.
    expect_frame(0, 1'b0, 1'b0);

    run_load("hex_a5f3", 16'hA5F3, 1'b0, 1'b0);
    run_load("dec_1234", 1234, 1'b1, 1'b0);
    run_load("dec_12345", 12345, 1'b1, 1'b0);
    run_load("hex_0007", 16'h0007, 1'b0, 1'b1);
    run_load("dec_9999", 9999, 1'b1, 1'b0);
    run_load("dec_0", 0, 1'b1, 1'b1);

    // The second load restarts the conversion, so 9999 must never land.
    blank_en = 1'b1;
    issue(9999, 1'b1);
    repeat (4) @(negedge clk);
    chk("restart_busy_mid", 32'(busy), 32'd1);
    issue(42, 1'b1);
    wait_busy("restart", 1'b1);
    expect_frame(42, 1'b1, 1'b1);
    // blank_en is live: the same buffer unblanked
    expect_frame(42, 1'b1, 1'b0);

    // Hex load aborting a decimal conversion
    blank_en = 1'b0;
    issue(7777, 1'b1);
    repeat (3) @(negedge clk);
    issue(16'h00B0, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    expect_frame(16'h00B0, 1'b0, 1'b1);

    // Randomized loads
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 65535));
        1:       v = int'($urandom_range(0, 9999));
        default: v = int'($urandom_range(0, 255));
      endcase
      d = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      run_load("rand", v, d, b);
    end

    // Reset in the middle of a conversion discards it and zeros the buffer
    issue(5678, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grounds", 32'(grounds), 32'd1);
    chk("midrst_display", 32'(display), 32'h3F);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    repeat (25) @(negedge clk);
    chk("midrst_busy_late", 32'(busy), 32'd0);
    expect_frame(0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
